// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings and phase enum for light controllers
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  typedef enum logic [2:0] {
    ALL_RED_A   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_B   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    FLASH       = 3'd6
  } phase_e;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that parks at zero
module phase_timer #(
  parameter int               CNT_W     = 6,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // load wins over decrement; the count rests at zero until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road phase sequencer, optional PED_CROSSING_EN walk support
module traffic_phase_scheduler #(
  parameter int GREEN_MAIN_CYC = 32,
  parameter int GREEN_SIDE_CYC = 16,
  parameter int YELLOW_CYC     = 4,
  parameter int ALLRED_CYC     = 2,
  parameter int FLASH_CYC      = 8,
  parameter int CNT_W          = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  import traffic_pkg::*;

  localparam logic [CNT_W-1:0] LD_MAIN   = CNT_W'(GREEN_MAIN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SIDE   = CNT_W'(GREEN_SIDE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_CYC - 1);

  phase_e           state, next_state;
  logic             toggle, next_toggle;
  logic             req_pending, req_in, enter_side;
  logic             load, zero;
  logic [CNT_W-1:0] load_val;
  logic [1:0]       main_next, side_next;

  phase_timer #(.CNT_W(CNT_W), .RESET_VAL(LD_ALLRED)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

`ifdef PED_CROSSING_EN
  assign req_in = side_req | ped_req;
`else
  logic unused_ped;
  assign req_in     = side_req;
  assign unused_ped = ped_req;
`endif

  assign enter_side = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);

  // next phase, timer reload and the light values the next phase will show
  always_comb begin
    next_state  = state;
    next_toggle = toggle;
    load        = 1'b0;
    load_val    = '0;
    main_next   = RED;
    side_next   = RED;
    case (state)
      ALL_RED_A:   if (zero) next_state = flash_en ? FLASH : MAIN_GREEN;
      MAIN_GREEN:  if (zero && req_pending) next_state = MAIN_YELLOW;
      MAIN_YELLOW: if (zero) next_state = ALL_RED_B;
      ALL_RED_B:   if (zero) next_state = flash_en ? FLASH : SIDE_GREEN;
      SIDE_GREEN:  if (zero) next_state = SIDE_YELLOW;
      SIDE_YELLOW: if (zero) next_state = ALL_RED_A;
      FLASH: begin
        if (zero) begin
          if (flash_en) begin
            next_toggle = ~toggle;
            load        = 1'b1;
            load_val    = LD_FLASH;
          end else begin
            next_state = ALL_RED_A;
          end
        end
      end
      default:     next_state = ALL_RED_A;
    endcase
    if (next_state != state) begin
      load        = 1'b1;
      next_toggle = 1'b0;
      case (next_state)
        MAIN_GREEN:  load_val = LD_MAIN;
        SIDE_GREEN:  load_val = LD_SIDE;
        MAIN_YELLOW,
        SIDE_YELLOW: load_val = LD_YELLOW;
        FLASH:       load_val = LD_FLASH;
        default:     load_val = LD_ALLRED;
      endcase
    end
    case (next_state)
      MAIN_GREEN:  main_next = GREEN;
      MAIN_YELLOW: main_next = YELLOW;
      SIDE_GREEN:  side_next = GREEN;
      SIDE_YELLOW: side_next = YELLOW;
      FLASH: begin
        main_next = next_toggle ? OFF : YELLOW;
        side_next = next_toggle ? OFF : RED;
      end
      default: begin
        main_next = RED;
        side_next = RED;
      end
    endcase
  end

  // phase, lights and request latch; a new request beats the clear on side green entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ALL_RED_A;
      toggle      <= 1'b0;
      main_light  <= RED;
      side_light  <= RED;
      req_pending <= 1'b0;
    end else begin
      state       <= next_state;
      toggle      <= next_toggle;
      main_light  <= main_next;
      side_light  <= side_next;
      req_pending <= req_in | (req_pending & ~enter_side);
    end
  end

`ifdef PED_CROSSING_EN
  logic ped_pending;

  // walk follows the pedestrian latch as sampled on side green entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending <= 1'b0;
      walk        <= 1'b0;
    end else begin
      ped_pending <= ped_req | (ped_pending & ~enter_side);
      if (enter_side) begin
        walk <= ped_pending;
      end else if (next_state != SIDE_GREEN) begin
        walk <= 1'b0;
      end
    end
  end
`else
  assign walk = 1'b0;
`endif

  assign phase = state;

endmodule
